// File: rtl/clock_ratio_detect.sv
// Measures the div_clk period in Ref_Clk cycles and tracks lock against exp_ratio.
// Optional duty-cycle check enabled by defining CLOCK_RATIO_DETECT_DUTY_CHECK_EN.
module clock_ratio_detect #(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 4,
    parameter int TOL      = 1
) (
    input  logic             Ref_Clk,
    input  logic             rst,
    input  logic             div_clk,
    input  logic [WIDTH-1:0] exp_ratio,
    output logic [WIDTH-1:0] meas_ratio,
    output logic             meas_valid,
    output logic             locked,
    output logic             lock_lost,
    output logic             timeout,
    output logic             duty_err
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam logic [WIDTH:0]  TOL_W  = TOL[WIDTH:0];
    localparam logic [MW-1:0]   LOCK_W = LOCK_CNT[MW-1:0];

    typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;
    state_t state_q, state_d;

    logic             sync1_q, sync_q, prev_q, rise;
    logic [WIDTH-1:0] cnt_q, exp_q;
    logic [MW-1:0]    mcnt_q, mcnt_d;
    logic             sat, exp_chg, match, lost_d, measure;
    logic [WIDTH:0]   diff;

    assign rise    = sync_q & ~prev_q;
    assign sat     = (cnt_q == {WIDTH{1'b1}}) && !rise;
    assign exp_chg = (exp_ratio != exp_q);
    assign measure = rise && (state_q != IDLE);
    assign locked  = (state_q == LOCKED);

    assign diff  = (cnt_q >= exp_ratio) ? ({1'b0, cnt_q} - {1'b0, exp_ratio})
                                        : ({1'b0, exp_ratio} - {1'b0, cnt_q});
    // Zero expected ratio is treated as "no target": never matches.
    assign match = (exp_ratio != '0) && (diff <= TOL_W);

    always_ff @(posedge Ref_Clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            mcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        lost_d  = 1'b0;
        if (rise) begin
            case (state_q)
                IDLE: begin
                    state_d = ACQ;
                    mcnt_d  = '0;
                end
                ACQ: begin
                    if (exp_chg || !match) begin
                        mcnt_d = '0;
                    end else if (mcnt_q + MW'(1) >= LOCK_W) begin
                        state_d = LOCKED;
                        mcnt_d  = '0;
                    end else begin
                        mcnt_d = mcnt_q + MW'(1);
                    end
                end
                LOCKED: begin
                    if (exp_chg || !match) begin
                        state_d = ACQ;
                        mcnt_d  = '0;
                        lost_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (sat) begin
            state_d = IDLE;
            mcnt_d  = '0;
            lost_d  = (state_q == LOCKED);
        end else if (exp_chg && state_q != IDLE) begin
            state_d = ACQ;
            mcnt_d  = '0;
            lost_d  = (state_q == LOCKED);
        end
    end

    always_ff @(posedge Ref_Clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= 1'b0;
            sync_q     <= 1'b0;
            prev_q     <= 1'b0;
            cnt_q      <= '0;
            exp_q      <= '0;
            meas_ratio <= '0;
            meas_valid <= 1'b0;
            lock_lost  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            sync1_q    <= div_clk;
            sync_q     <= sync1_q;
            prev_q     <= sync_q;
            exp_q      <= exp_ratio;
            meas_valid <= measure;
            lock_lost  <= lost_d;
            if (measure) meas_ratio <= cnt_q;
            if (rise)         cnt_q <= WIDTH'(1);
            else if (!sat)    cnt_q <= cnt_q + WIDTH'(1);
            if (rise)         timeout <= 1'b0;
            else if (sat)     timeout <= 1'b1;
        end
    end

`ifdef CLOCK_RATIO_DETECT_DUTY_CHECK_EN
    localparam logic [WIDTH+1:0] TOL2 = (WIDTH+2)'(2 * TOL);
    logic [WIDTH-1:0] high_q;
    logic [WIDTH+1:0] twice_high, period_x, duty_diff;

    assign twice_high = {1'b0, high_q, 1'b0};
    assign period_x   = {2'b00, cnt_q};
    assign duty_diff  = (twice_high >= period_x) ? (twice_high - period_x)
                                                 : (period_x - twice_high);

    // The rise cycle itself is a high cycle, so the count restarts at 1.
    always_ff @(posedge Ref_Clk or negedge rst) begin
        if (!rst) begin
            high_q   <= '0;
            duty_err <= 1'b0;
        end else begin
            if (rise)                                high_q <= WIDTH'(1);
            else if (sync_q && high_q != {WIDTH{1'b1}}) high_q <= high_q + WIDTH'(1);
            if (state_q == IDLE)                     duty_err <= 1'b0;
            else if (measure && duty_diff > TOL2)    duty_err <= 1'b1;
        end
    end
`else
    assign duty_err = 1'b0;
`endif

endmodule
